// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter in front of a single-ported memory.
// One transaction at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> ACK -> IDLE.
// All outputs are registered. Optional macro MEM_ARB_RR_EN: on a tie in IDLE the
// port not granted last time wins; otherwise data always beats fetch.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 1,  // read latency after the m_en cycle, 1..15
    parameter int unsigned AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [31:0]   i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_ack,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    output logic          busy,
    output logic          grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       txn_we;   // latched we of the transaction in flight
    logic       pick_d;   // data port wins the arbitration this cycle
`ifdef MEM_ARB_RR_EN
    logic       last_grant;
`endif

    // Winner selection for a request seen in IDLE
    always_comb begin
`ifdef MEM_ARB_RR_EN
        pick_d = d_req && (!i_req || !last_grant);
`else
        pick_d = d_req;
`endif
    end

    // Transaction FSM with registered outputs; rst overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            txn_we  <= 1'b0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            busy    <= 1'b0;
            grant   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state   <= ISSUE;
                        busy    <= 1'b1;
                        m_en    <= 1'b1;
                        grant   <= pick_d;
                        txn_we  <= pick_d & d_we;
                        m_we    <= pick_d & d_we;
                        m_addr  <= pick_d ? d_addr : i_addr;
                        m_wdata <= pick_d ? d_wdata : 32'd0;
`ifdef MEM_ARB_RR_EN
                        last_grant <= pick_d;
`endif
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    m_en  <= 1'b0;
                    m_we  <= 1'b0;
                    cnt   <= 4'(MEM_LAT);
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        // m_rdata is valid in this last WAIT cycle
                        state <= ACK;
                        cnt   <= 4'd0;
                        if (grant) begin
                            d_ack <= 1'b1;
                            if (!txn_we) d_rdata <= m_rdata;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1: memory read latency in cycles after the m_en cycle; legal range 1..15.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_req  input  1  instruction-fetch request; level-held until i_ack.
REQ-006 i_addr  input  AW  fetch address.
REQ-007 i_rdata  output  32  fetched word; valid while i_ack=1.
REQ-008 i_ack  output  1  one-cycle completion pulse for the fetch port.
REQ-009 d_req  input  1  data request; level-held until d_ack.
REQ-010 d_we  input  1  1=store, 0=load.
REQ-011 d_addr  input  AW  data address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_rdata  output  32  load data; valid while d_ack=1.
REQ-014 d_ack  output  1  one-cycle completion pulse for the data port.
REQ-015 m_en  output  1  single-ported memory access strobe, one cycle per transaction.
REQ-016 m_we  output  1  memory write enable; only ever 1 while m_en=1.
REQ-017 m_addr  output  AW  memory address.
REQ-018 m_wdata  output  32  memory write data.
REQ-019 m_rdata  input  32  memory read data, valid MEM_LAT cycles after the m_en cycle.
REQ-020 busy  output  1  1 in every state except IDLE.
REQ-021 grant  output  1  owner of the current transaction: 0=fetch, 1=data; holds its last value in IDLE.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT and ACK, with all outputs registered.
REQ-023 In IDLE with any request asserted, the FSM SHALL select a winner, latch its address, write data and we (fetch: we=0), and move to ISSUE.
REQ-024 ISSUE SHALL last one cycle with m_en=1, m_we=latched we, m_addr and m_wdata equal to the latched values; then the FSM SHALL move to WAIT with a 4-bit counter loaded to MEM_LAT.
REQ-025 WAIT SHALL last exactly MEM_LAT cycles; on the last WAIT cycle the arbiter SHALL capture m_rdata into the winner's rdata register (loads and fetches only).
REQ-026 ACK SHALL last one cycle, asserting only the winner's ack; then the FSM SHALL return to IDLE.
REQ-027 Latency: a request sampled in IDLE at cycle 0 SHALL produce m_en at cycle 1 and ack at cycle 2+MEM_LAT.
REQ-028 A store SHALL leave d_rdata unchanged; the loser's rdata and ack SHALL be unaffected by the transaction.
REQ-029 A request still high in IDLE the cycle after its ack SHALL be treated as a new transaction.
REQ-030 Changes to request inputs outside IDLE SHALL be ignored; latched values govern the transaction in flight.
REQ-031 Priority: when both requests are high in IDLE, data SHALL win (fixed priority, unless REQ-036 applies).
REQ-032 Throughput: back-to-back transactions SHALL be separated by exactly one IDLE cycle.

Reset
REQ-033 With rst=1 at an edge, the FSM SHALL go to IDLE and the registers SHALL be set as follows: m_en=0, m_we=0, i_ack=0, d_ack=0, busy=0, grant=0, m_addr=0, m_wdata=0, i_rdata=0, d_rdata=0, counter=0.
REQ-034 Reset mid-transaction SHALL drop that transaction without any ack; the requester SHALL reissue it.
REQ-035 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-036 Macro MEM_ARB_RR_EN defined: on a tie in IDLE, the arbiter SHALL grant the port not granted in the previous transaction; a last-grant register resets to 0 (fetch), so the first tie goes to data.
REQ-037 Macro MEM_ARB_RR_EN undefined: fixed data-over-fetch priority per REQ-031; no last-grant register.

Verification
REQ-038 MEM_LAT=1, i_req=1, i_addr=0x0000_0010, m_rdata=0x0000_0513 -> m_en at cycle 1 (m_we=0, m_addr=0x10), i_ack at cycle 3 with i_rdata=0x0000_0513.
REQ-039 d_req=1, d_we=1, d_addr=0x0000_0100, d_wdata=0xDEAD_BEEF -> m_en=m_we=1 for one cycle with those values; d_ack at cycle 3; d_rdata unchanged.
REQ-040 i_req and d_req rise in the same cycle, both held -> data served first, fetch second, with one IDLE cycle between d_ack and the fetch m_en; with MEM_ARB_RR_EN a third tie goes to data after the fetch.
REQ-041 MEM_LAT=4 load -> d_ack exactly 6 cycles after the request is sampled; busy=1 for cycles 1..6.
REQ-042 rst=1 asserted during WAIT -> next cycle IDLE, busy=0, no ack ever issued; a reissued request completes normally.
